flag_collision_detector: RTL and testbench
==========================================

FLAG_COLLISION_DETECTOR -- requirements
Module: flag_collision_detector

Interface
REQ-001 Parameter: HIT_SIZE, default 16, per-axis hit window in pixels (hit when |diff| < HIT_SIZE).
REQ-002 Clk  input  1  system clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 frame_start  input  1  single-cycle strobe, once per video frame (vsync-derived).
REQ-005 car_x  input  10  player car X position, unsigned pixels.
REQ-006 car_y  input  10  player car Y position, unsigned pixels.
REQ-007 flagDisplay  input  5  per-flag "still on field" mask from the flag bookkeeping block; bit i=1 means flag i is collectable.
REQ-008 flagBurst  output  5  one-hot, single-cycle collision pulse per flag; registered.
REQ-009 busy  output  1  high whenever FSM is not in IDLE.
REQ-010 overrun  output  1  single-cycle pulse when frame_start arrives while busy.

Function
REQ-011 FSM states SHALL be IDLE, SCAN, REPORT.
REQ-012 IDLE: on frame_start=1, capture car_x/car_y into snapshot registers, clear pending[4:0], set idx=0, go to SCAN.
REQ-013 SCAN: each cycle evaluate flag idx against snapshot and flagDisplay[idx] sampled that cycle; set pending[idx] on hit; idx increments 0..4; after idx=4, go to REPORT.
REQ-014 Hit rule: flagDisplay[idx]=1 AND |snap_x-FLAG_X[idx]| < HIT_SIZE AND |snap_y-FLAG_Y[idx]| < HIT_SIZE.
REQ-015 Differences SHALL be computed as unsigned 11-bit magnitudes, no wrap-around; difference exactly HIT_SIZE is a miss.
REQ-016 REPORT: if pending nonzero, flagBurst <= one-hot of lowest set pending bit and clear that bit; otherwise flagBurst <= 0 and go to IDLE.
REQ-017 At most one flagBurst bit high per cycle; pulses for multiple hits SHALL be on consecutive cycles, lowest index first.
REQ-018 flagBurst SHALL be 0 in every cycle not driven by REQ-016.
REQ-019 Latency: frame_start sampled at edge E0 -> first flagBurst pulse visible after edge E6; no hits -> busy drops after E6.
REQ-020 frame_start while busy SHALL be ignored (no snapshot change, no restart) and pulse overrun for one cycle.
REQ-021 A flag whose flagDisplay bit is 0 during its SCAN cycle SHALL never pulse that frame.
REQ-022 Snapshot SHALL be unaffected by car_x/car_y changes during SCAN/REPORT.

Reset
REQ-023 Reset SHALL force state=IDLE, idx=0, pending=0, snapshot=0, flagBurst=0, busy=0, overrun=0.
REQ-024 Reset asserted mid-SCAN or mid-REPORT SHALL abort the frame; no further pulses for that frame after release.
REQ-025 First frame_start after Reset release SHALL start a normal scan.

Structure
REQ-026 Shared package (flag_pkg) SHALL hold NUM_FLAGS=5, FLAG_X[5]={100,200,300,400,500}, FLAG_Y[5]={80,160,240,320,400}, 10-bit coordinate typedef, FSM state enum.
REQ-027 One sub-module, abs_diff_cmp: combinational |a-b| < HIT_SIZE for one axis, instantiated twice.

Verification
REQ-028 Car (100,80), flagDisplay=11111, frame_start -> flagBurst=00001 for exactly one cycle after E6, busy low after E7.
REQ-029 Car (115,95), HIT_SIZE=16 -> 00001 pulse; car (116,80) -> no pulse, busy drops after E6.
REQ-030 FLAG_X[1..2] overridden to 200 and FLAG_Y[1..2] to 160 (both flags coincide), car (200,160) -> 00010 then 00100 on consecutive cycles.
REQ-031 Car (300,240), flagDisplay=11011 -> no pulse.
REQ-032 frame_start reasserted 2 cycles after first -> overrun pulses once, original frame pulses unchanged.
REQ-033 Reset asserted during REPORT with pending=00110 -> flagBurst=0 immediately, no pulses after release until next frame_start.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared constants and types for the flag collision detector.
// FLAG_X/FLAG_Y are the default flag table; the top can be built with another.
package flag_pkg;

    localparam int NUM_FLAGS = 5;
    localparam int COORD_W   = 10;

    typedef logic [COORD_W-1:0]                  coord_t;
    typedef logic [NUM_FLAGS-1:0]                flag_mask_t;
    typedef logic [NUM_FLAGS-1:0][COORD_W-1:0]   coord_tbl_t;
    typedef logic [2:0]                          flag_idx_t;

    localparam flag_idx_t LAST_IDX = flag_idx_t'(NUM_FLAGS - 1);

    // Element [0] is the rightmost entry of each concatenation.
    localparam coord_tbl_t FLAG_X = {10'd500, 10'd400, 10'd300, 10'd200, 10'd100};
    localparam coord_tbl_t FLAG_Y = {10'd400, 10'd320, 10'd240, 10'd160, 10'd80};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    function automatic flag_mask_t lowest_one_hot(input flag_mask_t v);
        return v & (~v + flag_mask_t'(1));
    endfunction

endpackage

// File: rtl/flag_collision_detector_if.sv
// Frame-rate handshake between the game logic and the flag collision detector.
interface flag_collision_detector_if;
    import flag_pkg::*;

    logic       frame_start;
    coord_t     car_x;
    coord_t     car_y;
    flag_mask_t flagDisplay;
    flag_mask_t flagBurst;
    logic       busy;
    logic       overrun;

    modport master (
        output frame_start, car_x, car_y, flagDisplay,
        input  flagBurst, busy, overrun
    );

    modport slave (
        input  frame_start, car_x, car_y, flagDisplay,
        output flagBurst, busy, overrun
    );

endinterface

// File: rtl/abs_diff_cmp.sv
// One-axis proximity test: hit when |a - b| < HIT_SIZE, using an unsigned
// magnitude one bit wider than the coordinates so nothing wraps.
module abs_diff_cmp
    import flag_pkg::*;
#(
    parameter int unsigned HIT_SIZE = 16
) (
    input  coord_t a,
    input  coord_t b,
    output logic   hit
);

    logic [COORD_W:0] mag;

    always_comb begin
        if (a >= b) begin
            mag = {1'b0, a} - {1'b0, b};
        end else begin
            mag = {1'b0, b} - {1'b0, a};
        end
    end

    assign hit = ({{(32 - COORD_W - 1){1'b0}}, mag} < HIT_SIZE);

endmodule

// File: rtl/flag_collision_detector.sv
// Once per frame, snapshots the car position, scans the five flags one per
// cycle, then reports each hit as a single-cycle one-hot pulse, lowest first.
module flag_collision_detector
    import flag_pkg::*;
#(
    parameter int unsigned HIT_SIZE   = 16,
    parameter coord_tbl_t  FLAG_X_TBL = FLAG_X,
    parameter coord_tbl_t  FLAG_Y_TBL = FLAG_Y
) (
    input logic                      Clk,
    input logic                      Reset,
    flag_collision_detector_if.slave bus
);

    state_e     state_q,      state_d;
    flag_idx_t  idx_q,        idx_d;
    flag_mask_t pending_q,    pending_d;
    point_t     snap_q,       snap_d;
    flag_mask_t flag_burst_q, flag_burst_d;
    logic       overrun_q,    overrun_d;

    logic hit_x;
    logic hit_y;
    logic flag_hit;

    abs_diff_cmp #(.HIT_SIZE(HIT_SIZE)) u_cmp_x (
        .a   (snap_q.x),
        .b   (FLAG_X_TBL[idx_q]),
        .hit (hit_x)
    );

    abs_diff_cmp #(.HIT_SIZE(HIT_SIZE)) u_cmp_y (
        .a   (snap_q.y),
        .b   (FLAG_Y_TBL[idx_q]),
        .hit (hit_y)
    );

    // The display mask is sampled live, so a flag collected earlier this frame is skipped.
    assign flag_hit = bus.flagDisplay[idx_q] && hit_x && hit_y;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        snap_d       = snap_q;
        flag_burst_d = '0;
        overrun_d    = bus.frame_start && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    snap_d.x  = bus.car_x;
                    snap_d.y  = bus.car_y;
                    pending_d = '0;
                    idx_d     = '0;
                    state_d   = SCAN;
                end
            end

            SCAN: begin
                if (flag_hit) begin
                    pending_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + flag_idx_t'(1);
                end
            end

            REPORT: begin
                if (pending_q != '0) begin
                    flag_burst_d = lowest_one_hot(pending_q);
                    pending_d    = pending_q & ~flag_burst_d;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pending_q    <= '0;
            snap_q       <= '0;
            flag_burst_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            snap_q       <= snap_d;
            flag_burst_q <= flag_burst_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.flagBurst = flag_burst_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;

    // Structural invariants of the reporting scheme.
    a_burst_onehot: assert property (@(posedge Clk) disable iff (Reset)
        $onehot0(flag_burst_q));
    a_burst_in_report: assert property (@(posedge Clk) disable iff (Reset)
        (flag_burst_q != '0) |-> (state_q == REPORT));
    a_idx_range: assert property (@(posedge Clk) disable iff (Reset)
        idx_q <= LAST_IDX);

endmodule

// File: tb/tb_flag_collision_detector.sv
// Scoreboard bench: two detectors (default flag table, and one with flags 1 and 2
// stacked on each other) share all stimulus; each has its own expectation queue.
module tb_flag_collision_detector;
    import flag_pkg::*;

    localparam int HIT = 16;
    localparam int FX0 [NUM_FLAGS] = '{100, 200, 300, 400, 500};
    localparam int FY0 [NUM_FLAGS] = '{80, 160, 240, 320, 400};
    localparam int FX1 [NUM_FLAGS] = '{100, 200, 200, 400, 500};
    localparam int FY1 [NUM_FLAGS] = '{80, 160, 160, 320, 400};
    localparam coord_tbl_t OVR_X = {10'd500, 10'd400, 10'd200, 10'd200, 10'd100};
    localparam coord_tbl_t OVR_Y = {10'd400, 10'd320, 10'd160, 10'd160, 10'd80};

    typedef struct packed {
        flag_mask_t burst;
        logic       busy;
        logic       overrun;
    } exp_t;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;
    exp_t sb0 [$];
    exp_t sb1 [$];

    flag_collision_detector_if bus ();
    flag_collision_detector_if bus_ovr ();

    flag_collision_detector #(.HIT_SIZE(HIT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    flag_collision_detector #(.HIT_SIZE(HIT), .FLAG_X_TBL(OVR_X), .FLAG_Y_TBL(OVR_Y)) dut_ovr (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_ovr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic flag_mask_t model_hits(input bit ovr, input int x, input int y,
                                              input flag_mask_t disp);
        flag_mask_t h;
        int fx, fy, dx, dy;
        h = '0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            fx = ovr ? FX1[i] : FX0[i];
            fy = ovr ? FY1[i] : FY0[i];
            dx = (x > fx) ? x - fx : fx - x;
            dy = (y > fy) ? y - fy : fy - y;
            if (disp[i] && dx < HIT && dy < HIT) h[i] = 1'b1;
        end
        return h;
    endfunction

    task automatic drive(input logic fs, input int x, input int y, input flag_mask_t disp);
        bus.frame_start     = fs;
        bus.car_x           = coord_t'(x);
        bus.car_y           = coord_t'(y);
        bus.flagDisplay     = disp;
        bus_ovr.frame_start = fs;
        bus_ovr.car_x       = coord_t'(x);
        bus_ovr.car_y       = coord_t'(y);
        bus_ovr.flagDisplay = disp;
    endtask

    // Expected outputs after edges E0..E(len-1), E0 being the frame_start edge.
    task automatic push_frame(input bit ovr, input int x, input int y, input flag_mask_t disp,
                              input int restrike, input int len);
        flag_mask_t rem;
        int n;
        exp_t e;
        rem = model_hits(ovr, x, y, disp);
        n = $countones(rem);
        for (int k = 0; k < len; k++) begin
            e.burst   = '0;
            e.busy    = (k <= 5 + n);
            e.overrun = (k == restrike);
            if (k >= 6) begin
                for (int i = 0; i < NUM_FLAGS; i++) begin
                    if (rem[i] && e.burst == '0) begin
                        e.burst[i] = 1'b1;
                        rem[i] = 1'b0;
                    end
                end
            end
            if (ovr) sb1.push_back(e);
            else     sb0.push_back(e);
        end
    endtask

    // Called at a negedge with both detectors idle. Car inputs are scrambled
    // after E0 to confirm the snapshot holds.
    task automatic run_frame(input string name, input int x, input int y, input flag_mask_t disp,
                             input int restrike, input int tail);
        int n0, n1, len;
        exp_t e;
        flag_mask_t got;
        n0  = $countones(model_hits(1'b0, x, y, disp));
        n1  = $countones(model_hits(1'b1, x, y, disp));
        len = 7 + ((n0 > n1) ? n0 : n1) + tail;
        push_frame(1'b0, x, y, disp, restrike, len);
        push_frame(1'b1, x, y, disp, restrike, len);
        drive(1'b1, x, y, disp);
        for (int k = 0; k < len; k++) begin
            @(negedge Clk);
            e = sb0.pop_front();
            got = bus.flagBurst;
            checks++;
            if ({got, bus.busy, bus.overrun} !== {e.burst, e.busy, e.overrun}) begin
                errors++;
                $display("FAIL %s dut k=%0d: burst=%b busy=%b overrun=%b, expected burst=%b busy=%b overrun=%b",
                         name, k, got, bus.busy, bus.overrun, e.burst, e.busy, e.overrun);
            end
            e = sb1.pop_front();
            got = bus_ovr.flagBurst;
            checks++;
            if ({got, bus_ovr.busy, bus_ovr.overrun} !== {e.burst, e.busy, e.overrun}) begin
                errors++;
                $display("FAIL %s dut_ovr k=%0d: burst=%b busy=%b overrun=%b, expected burst=%b busy=%b overrun=%b",
                         name, k, got, bus_ovr.busy, bus_ovr.overrun, e.burst, e.busy, e.overrun);
            end
            drive((k + 1 == restrike), $urandom_range(0, 1023), $urandom_range(0, 1023), disp);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        drive(1'b0, 0, 0, '0);
        repeat (3) @(negedge Clk);
        checks++;
        if ({bus.flagBurst, bus.busy, bus.overrun, bus_ovr.flagBurst, bus_ovr.busy, bus_ovr.overrun} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b %b %b / %b %b %b, expected all zero",
                     bus.flagBurst, bus.busy, bus.overrun, bus_ovr.flagBurst, bus_ovr.busy, bus_ovr.overrun);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({bus.flagBurst, bus.busy, bus.overrun, bus_ovr.flagBurst, bus_ovr.busy, bus_ovr.overrun} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%b %b %b / %b %b %b, expected all zero",
                     bus.flagBurst, bus.busy, bus.overrun, bus_ovr.flagBurst, bus_ovr.busy, bus_ovr.overrun);
        end
    endtask

    task automatic test_exact_hit;
        run_frame("exact_hit", 100, 80, 5'b11111, -1, 2);
    endtask

    task automatic test_window_edges;
        run_frame("inside_edge_hi", 115, 95, 5'b11111, -1, 1);
        run_frame("outside_edge_x", 116, 80, 5'b11111, -1, 1);
        run_frame("inside_edge_lo", 85, 65, 5'b11111, -1, 1);
        run_frame("outside_edge_y", 100, 64, 5'b11111, -1, 1);
        run_frame("near_origin", 0, 0, 5'b11111, -1, 1);
        run_frame("far_corner", 1023, 1023, 5'b11111, -1, 1);
    endtask

    task automatic test_display_mask;
        run_frame("masked_flag2", 300, 240, 5'b11011, -1, 1);
        run_frame("shown_flag2", 300, 240, 5'b11111, -1, 1);
        run_frame("masked_flag4", 500, 400, 5'b01111, -1, 1);
    endtask

    task automatic test_multi_hit;
        run_frame("coincident_flags", 200, 160, 5'b11111, -1, 2);
        run_frame("coincident_mask1", 200, 160, 5'b11101, -1, 1);
    endtask

    task automatic test_overrun;
        run_frame("overrun", 400, 320, 5'b11111, 2, 3);
    endtask

    task automatic test_back_to_back;
        run_frame("b2b_a", 200, 160, 5'b11111, -1, 0);
        run_frame("b2b_b", 100, 80, 5'b11111, -1, 0);
        run_frame("b2b_c", 300, 250, 5'b11111, -1, 1);
    endtask

    task automatic test_reset_mid_report;
        drive(1'b1, 200, 160, 5'b11111);
        @(negedge Clk);
        drive(1'b0, 0, 0, 5'b11111);
        repeat (5) @(negedge Clk);
        checks++;
        if (bus_ovr.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_report_busy: busy=%b, expected 1", bus_ovr.busy);
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({bus.flagBurst, bus.busy, bus_ovr.flagBurst, bus_ovr.busy} !== '0) begin
            errors++;
            $display("FAIL mid_report_reset: burst=%b busy=%b / burst=%b busy=%b, expected all zero",
                     bus.flagBurst, bus.busy, bus_ovr.flagBurst, bus_ovr.busy);
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            checks++;
            if ({bus.flagBurst, bus.busy, bus_ovr.flagBurst, bus_ovr.busy} !== '0) begin
                errors++;
                $display("FAIL post_reset_quiet k=%0d: burst=%b busy=%b / burst=%b busy=%b, expected all zero",
                         k, bus.flagBurst, bus.busy, bus_ovr.flagBurst, bus_ovr.busy);
            end
        end
        run_frame("first_after_reset", 100, 80, 5'b11111, -1, 1);
    endtask

    task automatic test_random;
        int i, x, y;
        for (int f = 0; f < 12; f++) begin
            i = $urandom_range(0, NUM_FLAGS - 1);
            x = FX0[i] + $urandom_range(0, 40) - 20;
            y = FY0[i] + $urandom_range(0, 40) - 20;
            run_frame("random", x, y, flag_mask_t'($urandom_range(0, 31)), -1, $urandom_range(0, 2));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exact_hit();
        test_window_edges();
        test_display_mask();
        test_multi_hit();
        test_overrun();
        test_back_to_back();
        test_reset_mid_report();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
